// File: rtl/tx_frame_arbiter_if.sv
// Lane-side bundle for the TX framing arbiter: TLP/DLLP sources in, framed symbols out.
// slave is the arbiter's view; master is the view of the sources and the lane.
interface tx_frame_arbiter_if;
  logic       tlp_valid;
  logic [7:0] tlp_data;
  logic       tlp_last;
  logic       tlp_abort;
  logic       tlp_ready;
  logic       dllp_valid;
  logic [7:0] dllp_data;
  logic       dllp_ready;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_dk;
  logic       out_valid;
  logic [1:0] grant;

  modport slave (
    input  tlp_valid, tlp_data, tlp_last, tlp_abort,
    input  dllp_valid, dllp_data, out_ready,
    output tlp_ready, dllp_ready, out_data, out_dk, out_valid, grant
  );

  modport master (
    output tlp_valid, tlp_data, tlp_last, tlp_abort,
    output dllp_valid, dllp_data, out_ready,
    input  tlp_ready, dllp_ready, out_data, out_dk, out_valid, grant
  );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin per-packet arbiter framing TLPs (STP..END/EDB) and DLLPs (SDP..END) onto one lane.
// One-cycle registered output; out_ready=0 freezes all state, source readies drop with it.
module tx_frame_arbiter #(
  parameter int DLLP_LEN = 6,
  parameter bit IDLE_PAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  tx_frame_arbiter_if.slave lane
);

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_PAD = 8'hF7;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_TLP  = 2'b01;
  localparam logic [1:0] GNT_DLLP = 2'b10;

  localparam logic [3:0] CNT_LAST = 4'(DLLP_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    TLP_DATA,
    TLP_END,
    DLLP_DATA,
    DLLP_END
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_dk_q, out_dk_d;
  logic       out_valid_q, out_valid_d;
  logic       pick_tlp;
  logic       pick_dllp;

  // On a tie the source that did not win last time goes first.
  assign pick_tlp  = lane.tlp_valid & (~lane.dllp_valid | (last_grant_q == GNT_DLLP));
  assign pick_dllp = lane.dllp_valid & ~pick_tlp;

  assign lane.tlp_ready  = lane.out_ready & (state_q == TLP_DATA);
  assign lane.dllp_ready = lane.out_ready & (state_q == DLLP_DATA);
  assign lane.out_data   = out_data_q;
  assign lane.out_dk     = out_dk_q;
  assign lane.out_valid  = out_valid_q;
  assign lane.grant      = grant_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_dk_d     = out_dk_q;
    out_valid_d  = out_valid_q;

    if (lane.out_ready) begin
      case (state_q)
        IDLE: begin
          if (pick_tlp) begin
            out_data_d   = SYM_STP;
            out_dk_d     = 1'b1;
            out_valid_d  = 1'b1;
            state_d      = TLP_DATA;
            grant_d      = GNT_TLP;
            last_grant_d = GNT_TLP;
          end else if (pick_dllp) begin
            out_data_d   = SYM_SDP;
            out_dk_d     = 1'b1;
            out_valid_d  = 1'b1;
            cnt_d        = 4'd0;
            state_d      = DLLP_DATA;
            grant_d      = GNT_DLLP;
            last_grant_d = GNT_DLLP;
          end else begin
            out_data_d  = IDLE_PAD ? SYM_PAD : 8'h00;
            out_dk_d    = IDLE_PAD;
            out_valid_d = IDLE_PAD;
            grant_d     = GNT_NONE;
          end
        end

        TLP_DATA: begin
          if (lane.tlp_valid) begin
            // Abort wins over last: the aborting byte itself is dropped.
            if (lane.tlp_abort) begin
              out_data_d  = SYM_EDB;
              out_dk_d    = 1'b1;
              out_valid_d = 1'b1;
              state_d     = IDLE;
            end else begin
              out_data_d  = lane.tlp_data;
              out_dk_d    = 1'b0;
              out_valid_d = 1'b1;
              if (lane.tlp_last) begin
                state_d = TLP_END;
              end
            end
          end else begin
            out_data_d  = 8'h00;
            out_dk_d    = 1'b0;
            out_valid_d = 1'b0;
          end
        end

        TLP_END: begin
          out_data_d  = SYM_END;
          out_dk_d    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end

        DLLP_DATA: begin
          if (lane.dllp_valid) begin
            out_data_d  = lane.dllp_data;
            out_dk_d    = 1'b0;
            out_valid_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = 4'd0;
              state_d = DLLP_END;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            out_data_d  = 8'h00;
            out_dk_d    = 1'b0;
            out_valid_d = 1'b0;
          end
        end

        DLLP_END: begin
          out_data_d  = SYM_END;
          out_dk_d    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      grant_q      <= GNT_NONE;
      last_grant_q <= GNT_TLP;
      out_data_q   <= 8'h00;
      out_dk_q     <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_dk_q     <= out_dk_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: directed frames queue expected symbols, a negedge monitor pops them.
module tb_tx_frame_arbiter;

  localparam int DLEN = 6;

  typedef struct packed {
    logic [1:0] grant;
    logic       dk;
    logic [7:0] data;
  } sym_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int pad_cnt   = 0;
  int tlp_acc   = 0;
  sym_t exp_q[$];

  tx_frame_arbiter_if lane();

  tx_frame_arbiter #(.DLLP_LEN(DLEN), .IDLE_PAD(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .lane(lane.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] d, input logic dk, input logic [1:0] g);
    sym_t s;
    s.data  = d;
    s.dk    = dk;
    s.grant = g;
    exp_q.push_back(s);
  endtask

  // n payload bytes, byte i at bytes[8*i+:8]; abort_at<0 means a normal END.
  task automatic push_tlp(input logic [63:0] bytes, input int n, input int abort_at);
    push(8'hFB, 1'b1, 2'b01);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        push(8'hFE, 1'b1, 2'b01);
        return;
      end
      push(bytes[8*i +: 8], 1'b0, 2'b01);
    end
    push(8'hFD, 1'b1, 2'b01);
  endtask

  task automatic push_dllp(input logic [63:0] bytes);
    push(8'h5C, 1'b1, 2'b10);
    for (int i = 0; i < DLEN; i++) push(bytes[8*i +: 8], 1'b0, 2'b10);
    push(8'hFD, 1'b1, 2'b10);
  endtask

  task automatic send_tlp(input logic [63:0] bytes, input int n, input int abort_at);
    bit ok;
    for (int i = 0; i < n; i++) begin
      lane.tlp_valid = 1'b1;
      lane.tlp_data  = bytes[8*i +: 8];
      lane.tlp_last  = (i == n - 1);
      lane.tlp_abort = (i == abort_at);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (rst) break;
        if (lane.tlp_ready) begin
          @(posedge clk);
          #1;
          ok = 1'b1;
          break;
        end
      end
      if (rst) break;
      if (!ok) begin
        total_cnt++;
        $display("FAIL tlp_accept_timeout: byte %0d not accepted within 200 cycles", i);
        break;
      end
      if (i == abort_at) break;
    end
    lane.tlp_valid = 1'b0;
    lane.tlp_last  = 1'b0;
    lane.tlp_abort = 1'b0;
  endtask

  task automatic send_dllp(input logic [63:0] bytes);
    bit ok;
    for (int i = 0; i < DLEN; i++) begin
      lane.dllp_valid = 1'b1;
      lane.dllp_data  = bytes[8*i +: 8];
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (lane.dllp_ready) begin
          @(posedge clk);
          #1;
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        total_cnt++;
        $display("FAIL dllp_accept_timeout: byte %0d not accepted within 200 cycles", i);
        break;
      end
    end
    lane.dllp_valid = 1'b0;
  endtask

  // Returns at posedge+2 right after the monitor consumed the last expected symbol.
  task automatic wait_drain(input string name);
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) return;
    end
    total_cnt++;
    $display("FAIL %s_drain_timeout: %0d symbols still expected", name, exp_q.size());
    exp_q.delete();
  endtask

  task automatic chk_out(input string name, input logic [7:0] d, input logic dk, input logic v, input logic [1:0] g);
    chk({name, "_data"},  32'(lane.out_data),  32'(d));
    chk({name, "_dk"},    32'(lane.out_dk),    32'(dk));
    chk({name, "_valid"}, 32'(lane.out_valid), 32'(v));
    chk({name, "_grant"}, 32'(lane.grant),     32'(g));
  endtask

  always @(negedge clk) begin
    if (!rst && lane.out_valid && lane.out_ready) begin
      if (lane.out_dk && lane.out_data == 8'hF7) begin
        pad_cnt++;
        chk("pad_grant", 32'(lane.grant), 32'd0);
      end else if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_sym: got data %h dk %b grant %b, nothing expected",
                 lane.out_data, lane.out_dk, lane.grant);
      end else begin
        sym_t e;
        e = exp_q.pop_front();
        chk("sym", 32'({lane.grant, lane.out_dk, lane.out_data}), 32'(e));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && lane.tlp_valid && lane.tlp_ready) tlp_acc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int pad0;
    bit seen;

    lane.tlp_valid  = 1'b0;
    lane.tlp_data   = 8'h00;
    lane.tlp_last   = 1'b0;
    lane.tlp_abort  = 1'b0;
    lane.dllp_valid = 1'b0;
    lane.dllp_data  = 8'h00;
    lane.out_ready  = 1'b1;

    // Reset values, then PAD on the first edge after release.
    #3;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_out("first_pad", 8'hF7, 1'b1, 1'b1, 2'b00);

    // Single TLP, followed by PAD.
    push_tlp(64'hA3A2A1, 3, -1);
    send_tlp(64'hA3A2A1, 3, -1);
    wait_drain("tlp1");
    chk_out("post_tlp_pad", 8'hF7, 1'b1, 1'b1, 2'b00);

    // DLLP of DLEN bytes; ready drops once the last byte is taken.
    push_dllp(64'h151413121110);
    send_dllp(64'h151413121110);
    chk("dllp_ready_after_last", 32'(lane.dllp_ready), 32'd0);
    chk("dllp_grant_held", 32'(lane.grant), 32'd2);
    wait_drain("dllp1");

    // Abort on the second byte, then a normal TLP.
    push_tlp(64'hB2B1, 2, 1);
    send_tlp(64'hB2B1, 2, 1);
    wait_drain("abort");
    chk_out("post_abort", 8'hF7, 1'b1, 1'b1, 2'b00);
    push_tlp(64'hC1, 1, -1);
    send_tlp(64'hC1, 1, -1);
    wait_drain("after_abort");

    // Backpressure: freeze for 3 cycles while A1 is on the lane.
    push_tlp(64'hA3A2A1, 3, -1);
    fork
      send_tlp(64'hA3A2A1, 3, -1);
      begin
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
          @(posedge clk);
          #1;
          if (lane.out_valid && !lane.out_dk && lane.out_data == 8'hA1) begin
            seen = 1'b1;
            break;
          end
        end
        chk("bp_saw_a1", 32'(seen), 32'd1);
        lane.out_ready = 1'b0;
        acc0 = tlp_acc;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk);
          #1;
          chk("bp_hold_data", 32'(lane.out_data), 32'hA1);
          chk("bp_tlp_ready", 32'(lane.tlp_ready), 32'd0);
        end
        chk("bp_no_consume", 32'(tlp_acc), 32'(acc0));
        lane.out_ready = 1'b1;
      end
    join
    wait_drain("backpressure");

    // Reset mid-packet: everything clears at once, no END/EDB.
    push_tlp(64'hD1, 1, -1);
    void'(exp_q.pop_back());
    fork
      send_tlp(64'hD3D2D1, 3, -1);
      begin
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
          @(posedge clk);
          #1;
          if (lane.out_valid && !lane.out_dk && lane.out_data == 8'hD1) begin
            seen = 1'b1;
            break;
          end
        end
        chk("midrst_saw_d1", 32'(seen), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_out("midrst", 8'h00, 1'b0, 1'b0, 2'b00);
      end
    join
    chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);

    // Tie arbitration from reset: DLLP first, then alternating, no PAD in between.
    push_dllp(64'h252423222120);
    push_tlp(64'h3231, 2, -1);
    push_dllp(64'h454443424140);
    push_tlp(64'h5251, 2, -1);
    pad0 = pad_cnt;
    #1;
    rst = 1'b0;
    fork
      begin
        send_dllp(64'h252423222120);
        send_dllp(64'h454443424140);
      end
      begin
        send_tlp(64'h3231, 2, -1);
        send_tlp(64'h5251, 2, -1);
      end
    join
    wait_drain("tie");
    chk("tie_no_pad", 32'(pad_cnt), 32'(pad0));
    chk_out("tie_end_pad", 8'hF7, 1'b1, 1'b1, 2'b00);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
